keccak_sponge_ctrl: RTL
=======================

// Module: keccak_sponge_ctrl
// PURPOSE
//  Sequencer for the 2-round-unrolled Keccak-f[1600] sponge datapath (SHA3-256, 1088-bit rate).
//  Accepts message blocks from the host with a valid/ready handshake and drives the datapath controls.
//  Controls: state clear, block absorb, round enable and round index. Runs ROUNDS/UNROLL cycles per block.
//  Holds digest_valid until the host acknowledges it. Sits between the input scan buffer/host and the round datapath.
// PARAMETERS
//  ROUNDS   24  Keccak-f rounds per permutation
//  UNROLL   2   rounds evaluated per clock by the datapath; ROUNDS % UNROLL == 0
//  BCNT_W   16  width of blocks-absorbed counter
// PORTS
//  clk            in   1       datapath clock
//  reset          in   1       asynchronous, active-high; all state/outputs to reset values
//  flush          in   1       synchronous abort of current message
//  blk_valid      in   1       input buffer holds a complete 1088-bit block
//  blk_last       in   1       qualifies blk_valid: final block of message
//  blk_ready      out  1       controller can accept a block this cycle
//  core_clear     out  1       datapath uses all-zero previous state (first block)
//  core_absorb    out  1       datapath XORs block into state this cycle
//  core_enable    out  1       datapath state/round registers update this cycle
//  round_idx      out  5       index of first round in current pair: 0,2,..,ROUNDS-UNROLL
//  busy           out  1       high in RUN
//  digest_valid   out  1       digest[255:0] on datapath is final
//  digest_ack     in   1       host consumed digest
//  blk_count      out  BCNT_W  blocks absorbed in current message, saturating
// BEHAVIOUR
//  States: IDLE, RUN, WAIT, DONE. Reset -> IDLE; all outputs 0 except blk_ready=1; blk_count=0.
//  Output decode: blk_ready=1 in IDLE/WAIT and not flush; busy=1 in RUN; digest_valid=1 in DONE.
//  accept = blk_valid & blk_ready.
//  Accept cycle = pair 0: core_enable=1, core_absorb=1, round_idx=0. core_clear=1 iff state==IDLE.
//  Also on accept: latch blk_last; blk_count+1, or set to 1 from IDLE; saturate at all-ones.
//  Accept cycle transitions to RUN with pair counter=1.
//  RUN: core_enable=1, core_absorb=0, core_clear=0, round_idx=pair*UNROLL. Pair counter runs 1..ROUNDS/UNROLL-1.
//  End of RUN: on pair==ROUNDS/UNROLL-1, next state is DONE if latched last, else WAIT.
//  WAIT: core_enable=0; state held; accept -> same as accept cycle with core_clear=0.
//  DONE: core_enable=0; digest_valid=1 until digest_ack. digest_ack -> IDLE next cycle, blk_count kept until next accept.
//  Timing: 12 enabled cycles per block (defaults). Digest_valid asserts the cycle after the last RUN cycle.
//  Max throughput: one block per 12 cycles when blk_valid is held high in WAIT.
//  Outside IDLE/WAIT: blk_valid ignored, no absorb.
//  Outside DONE: digest_ack ignored.
//  flush (any state): -> IDLE next cycle; outputs deasserted in the flush cycle; blk_count=0.
//  flush has priority over accept and digest_ack.
//  Reset mid-RUN: immediate return to IDLE values; the datapath is reset by the same signal.
//  core_* and round_idx are combinational from state/counter only, never from blk_valid except the accept cycle.
//  Datapath must register only when core_enable=1.
//  blk_last without blk_valid has no effect.
//  round_idx is 0 whenever core_enable=0.
// STRUCTURE
//  Shared package keccak_pkg: ROUNDS, UNROLL, RATE_BITS=1088, DIGEST_BITS=256, ctrl state encoding localparams.
//  One sub-module: keccak_round_cnt.
//    Pair counter with load-to-1, increment, and terminal-count flag.
//    Exports pair*UNROLL as round_idx.
//  FSM, handshake and blk_count stay in keccak_sponge_ctrl.
// TESTING
//  1. Reset, then a one-block message (blk_valid=1, blk_last=1):
//     accept at cycle 0 with clear=absorb=1; round_idx 0,2,..,22 over cycles 0..11.
//     digest_valid=1 from cycle 12; ack -> IDLE.
//  2. Three blocks with blk_valid held high: accepts at cycles 0, 12, 24.
//     core_clear only at cycle 0; blk_count=3; digest_valid at cycle 36.
//  3. blk_valid toggling during RUN and digest_ack pulses in RUN/WAIT: no extra absorb, no state change.
//     round_idx sequence unbroken.
//  4. flush at round_idx=10 with blk_valid=1 the same cycle: no accept; IDLE next cycle.
//     blk_count=0; the following block gets core_clear=1.
//  5. Async reset asserted mid-RUN, between clock edges: outputs go to reset values without a clk edge.
//     Restart yields the correct SHA3-256 digest of "abc" through the datapath.
//  6. DONE held 50 cycles without ack: digest_valid stays 1 and blk_ready stays 0.
//     Ack with blk_valid=1 -> IDLE, then accept on the next cycle.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared constants for the Keccak-f[1600] sponge controller and its round counter.
package keccak_pkg;

  localparam int KECCAK_ROUNDS = 24;
  localparam int KECCAK_UNROLL = 2;
  localparam int RATE_BITS     = 1088;
  localparam int DIGEST_BITS   = 256;
  localparam int ROUND_IDX_W   = 5;

  typedef logic [1:0] ctrl_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/keccak_round_cnt.sv
// Round-pair counter: load-to-1 on absorb, increment through RUN, flag the final pair.
module keccak_round_cnt #(
  parameter int PAIRS  = 12,
  parameter int UNROLL = 2,
  parameter int IDX_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [IDX_W-1:0] round_idx_o,
  output logic             tc_o
);

  localparam int CNT_W = (PAIRS > 2) ? $clog2(PAIRS) : 1;

  logic [CNT_W-1:0] pair_q, pair_d;

  always_comb begin
    pair_d = pair_q;
    if (clr_i)       pair_d = '0;
    else if (load_i) pair_d = CNT_W'(1);
    else if (inc_i)  pair_d = pair_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pair_q <= '0;
    else       pair_q <= pair_d;
  end

  assign round_idx_o = IDX_W'(32'(pair_q) * UNROLL);
  assign tc_o        = (pair_q == CNT_W'(PAIRS - 1));

endmodule

// File: rtl/keccak_sponge_ctrl.sv
// Sequencer for the 2-round-unrolled Keccak-f[1600] sponge: block handshake, round stepping, digest hold.
module keccak_sponge_ctrl
  import keccak_pkg::*;
#(
  parameter int ROUNDS = KECCAK_ROUNDS,
  parameter int UNROLL = KECCAK_UNROLL,
  parameter int BCNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   blk_valid,
  input  logic                   blk_last,
  output logic                   blk_ready,
  output logic                   core_clear,
  output logic                   core_absorb,
  output logic                   core_enable,
  output logic [ROUND_IDX_W-1:0] round_idx,
  output logic                   busy,
  output logic                   digest_valid,
  input  logic                   digest_ack,
  output logic [BCNT_W-1:0]      blk_count
);

  localparam int PAIRS = ROUNDS / UNROLL;

  ctrl_state_t              state_q, state_d;
  logic                     last_q, last_d;
  logic [BCNT_W-1:0]        bcnt_q, bcnt_d;
  logic                     accept, in_run, run_live, tc;
  logic [ROUND_IDX_W-1:0]   cnt_idx;

  assign in_run   = (state_q == ST_RUN);
  assign run_live = in_run & ~flush;

  // The accept cycle is itself pair 0, so round_idx stays 0 there while absorb is applied.
  assign blk_ready    = ((state_q == ST_IDLE) || (state_q == ST_WAIT)) && !flush;
  assign accept       = blk_valid & blk_ready;
  assign core_absorb  = accept;
  assign core_clear   = accept && (state_q == ST_IDLE);
  assign core_enable  = accept | run_live;
  assign busy         = run_live;
  assign digest_valid = (state_q == ST_DONE) && !flush;
  assign round_idx    = run_live ? cnt_idx : '0;
  assign blk_count    = bcnt_q;

  keccak_round_cnt #(
    .PAIRS  (PAIRS),
    .UNROLL (UNROLL),
    .IDX_W  (ROUND_IDX_W)
  ) u_round_cnt (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (flush),
    .load_i      (accept),
    .inc_i       (in_run & ~tc),
    .round_idx_o (cnt_idx),
    .tc_o        (tc)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    if (flush) begin
      state_d = ST_IDLE;
      last_d  = 1'b0;
      bcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_WAIT: begin
          if (accept) begin
            state_d = ST_RUN;
            last_d  = blk_last;
            if (state_q == ST_IDLE)  bcnt_d = BCNT_W'(1);
            else if (bcnt_q != '1)   bcnt_d = bcnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (tc) state_d = last_q ? ST_DONE : ST_WAIT;
        end
        ST_DONE: begin
          if (digest_ack) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

endmodule
